// File: rtl/mac_seq_ctrl.sv
// ============================================================================
// Module   : mac_seq_ctrl
// Purpose  : Sequencing controller for a product-register / accumulator MAC
//            pipeline; gathers NUM_TERMS operand pairs, then presents the sum.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mac_seq_ctrl #(
  parameter int NUM_TERMS = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             prod_en,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] term_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NUM_TERMS - 1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] term_cnt_q, term_cnt_d;
  logic             acc_clr_q, acc_clr_d;
  logic             acc_en_q, acc_en_d;
  logic             out_valid_q, out_valid_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      term_cnt_q  <= '0;
      acc_clr_q   <= 1'b0;
      acc_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      term_cnt_q  <= term_cnt_d;
      acc_clr_q   <= acc_clr_d;
      acc_en_q    <= acc_en_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    term_cnt_d = term_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          term_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (prod_en) begin
          term_cnt_d = term_cnt_q + C_ONE;
          if (term_cnt_q == C_LAST) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: state_d = S_HOLD;
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // acc_en trails prod_en by one cycle to line up with the product register.
  always_comb begin
    in_ready    = (state_q == S_RUN);
    prod_en     = in_valid & in_ready;
    busy        = (state_q != S_IDLE);
    acc_clr_d   = (state_q == S_IDLE) & start;
    acc_en_d    = prod_en;
    out_valid_d = (state_d == S_HOLD);
  end

  assign acc_clr   = acc_clr_q;
  assign acc_en    = acc_en_q;
  assign out_valid = out_valid_q;
  assign term_cnt  = term_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_seq_ctrl.sv
// ============================================================================
// Module   : tb_mac_seq_ctrl
// Purpose  : Randomised bench for mac_seq_ctrl (NUM_TERMS=16 and NUM_TERMS=1).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mac_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, in_valid, out_ready;
  logic [1:0] in_ready_v, prod_en_v, acc_clr_v, acc_en_v, out_valid_v, busy_v;
  logic [4:0] tc0;
  logic [0:0] tc1;

  mac_seq_ctrl #(.NUM_TERMS(16), .CNT_W(5)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready_v[0]), .prod_en(prod_en_v[0]), .acc_clr(acc_clr_v[0]),
    .acc_en(acc_en_v[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready),
    .busy(busy_v[0]), .term_cnt(tc0)
  );

  mac_seq_ctrl #(.NUM_TERMS(1), .CNT_W(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready_v[1]), .prod_en(prod_en_v[1]), .acc_clr(acc_clr_v[1]),
    .acc_en(acc_en_v[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready),
    .busy(busy_v[1]), .term_cnt(tc1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Job-level reference: a job is open from start until the sum is taken;
  // it counts accepts and the cycles elapsed since the final accept.
  int m_n[2] = '{16, 1};
  bit m_busy[2];
  int m_acc[2];
  int m_since[2];
  bit m_first[2];
  bit m_aen[2];

  function automatic bit m_inr(int i);
    return m_busy[i] && (m_acc[i] < m_n[i]);
  endfunction

  function automatic bit m_ov(int i);
    return m_busy[i] && (m_acc[i] == m_n[i]) && (m_since[i] >= 1);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_acc[i] = 0; m_since[i] = -1; m_first[i] = 0; m_aen[i] = 0;
    end
  endtask

  task automatic m_update();
    for (int i = 0; i < 2; i++) begin
      bit pr, ov;
      pr = m_inr(i) && in_valid;
      ov = m_ov(i);
      m_aen[i]   = pr;
      m_first[i] = 0;
      if (!m_busy[i]) begin
        if (start) begin
          m_busy[i] = 1; m_acc[i] = 0; m_since[i] = -1; m_first[i] = 1;
        end
      end else begin
        if (pr) begin
          m_acc[i]++;
          if (m_acc[i] == m_n[i]) m_since[i] = 0;
        end else if (m_since[i] >= 0) begin
          m_since[i]++;
        end
        if (ov && out_ready) m_busy[i] = 0;
      end
    end
  endtask

  // Inputs are set just after a falling edge; outputs are checked 1ns later,
  // the model advances at the rising edge.
  task automatic step();
    logic [31:0] tc;
    if (!rst) m_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      tc = (i == 0) ? 32'(tc0) : 32'(tc1);
      check_val($sformatf("d%0d_busy", i),      busy_v[i],      m_busy[i]);
      check_val($sformatf("d%0d_in_ready", i),  in_ready_v[i],  m_inr(i));
      check_val($sformatf("d%0d_prod_en", i),   prod_en_v[i],   m_inr(i) && in_valid);
      check_val($sformatf("d%0d_acc_clr", i),   acc_clr_v[i],   m_first[i]);
      check_val($sformatf("d%0d_acc_en", i),    acc_en_v[i],    m_aen[i]);
      check_val($sformatf("d%0d_out_valid", i), out_valid_v[i], m_ov(i));
      check_val($sformatf("d%0d_term_cnt", i),  tc,             m_acc[i]);
    end
    @(posedge clk);
    if (!rst) m_reset();
    else m_update();
    @(negedge clk);
  endtask

  task automatic full_job();
    int k;
    start = 1; in_valid = 1; out_ready = 1;
    step();
    start = 0;
    k = 0;
    while (busy_v[0] && k < 40) begin
      step();
      k++;
    end
    check_val("job_len_cycles", k + 1, 19);
  endtask

  initial begin
    int k;
    m_reset();
    rst = 0; start = 0; in_valid = 1; out_ready = 0;
    @(negedge clk);
    step(); step();
    rst = 1;
    for (int j = 0; j < 3; j++) step();

    full_job();
    step();

    // Bubbles, stray starts and backpressure in HOLD.
    start = 1; in_valid = 0; out_ready = 0;
    step();
    k = 0;
    while (m_acc[0] < 16 && k < 200) begin
      in_valid = (k % 3 == 0);
      start    = (k % 5 == 2);
      step();
      k++;
    end
    check_val("bubble_accepts", tc0, 16);
    in_valid = 1;
    for (int j = 0; j < 7; j++) begin
      start = (j % 2 == 0);
      step();
    end
    check_val("hold_out_valid", out_valid_v[0], 1);
    start = 0; out_ready = 1;
    step(); step();

    // Abandon a job part way through.
    start = 1; in_valid = 1;
    step();
    start = 0;
    k = 0;
    while (m_acc[0] < 7 && k < 50) begin
      step();
      k++;
    end
    rst = 0;
    #1;
    check_val("midjob_rst_cnt", tc0, 0);
    check_val("midjob_rst_busy", busy_v[0], 0);
    @(negedge clk);
    step();
    rst = 1;
    step();
    full_job();

    for (int j = 0; j < 3000; j++) begin
      rst       = ($urandom_range(0, 199) != 0);
      start     = ($urandom_range(0, 7) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
